// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encoding, opcode helpers.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // Ops that run on the multi-cycle engine rather than the single-cycle datapath.
  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result bundle between a producer (master) and the ALU (slave).
//
// Handshake: an operation transfers on a rising clk edge where i_valid && o_ready;
// the producer holds i_valid, i_control, i_a and i_b steady until that edge.
// A result transfers on a rising edge where o_valid && i_ready; the ALU holds
// o_result and its flags steady until that edge.
interface alu_seq_if #(
  parameter int DATA_WIDTH_P  = 32,
  parameter int CNTRL_WIDTH_P = 4
);
  logic                     i_valid;
  logic                     o_ready;
  logic [CNTRL_WIDTH_P-1:0] i_control;
  logic [DATA_WIDTH_P-1:0]  i_a;
  logic [DATA_WIDTH_P-1:0]  i_b;
  logic                     o_valid;
  logic                     i_ready;
  logic [DATA_WIDTH_P-1:0]  o_result;
  logic                     o_zero;
  logic                     o_overflow;
  logic                     o_err;

  modport master (
    output i_valid, i_control, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_result, o_zero, o_overflow, o_err
  );

  modport slave (
    input  i_valid, i_control, i_a, i_b, i_ready,
    output o_ready, o_valid, o_result, o_zero, o_overflow, o_err
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative engine: shift-add multiply (low W bits) and restoring unsigned divide.
// One step per cycle for DATA_WIDTH_P cycles; done marks the cycle of the last step,
// and result carries that last step's outcome so the caller can register it.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH_P = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [3:0]              op,
  input  logic [DATA_WIDTH_P-1:0] a,
  input  logic [DATA_WIDTH_P-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH_P-1:0] result
);
  localparam int W  = DATA_WIDTH_P;
  localparam int CW = $clog2(DATA_WIDTH_P) + 1;

  // acc: product accumulator (MUL) or partial remainder (DIVU/REMU).
  // sh:  multiplier shifting right (MUL) or dividend-in/quotient-out (DIVU/REMU).
  // opd: multiplicand shifting left (MUL) or divisor (DIVU/REMU).
  logic [W-1:0]  acc, sh, opd;
  logic [W-1:0]  acc_next, sh_next, opd_next;
  logic [3:0]    op_q;
  logic [CW-1:0] count;
  logic [W:0]    rem_sh;
  logic          ge;

  assign busy = (count != '0);
  assign done = (count == CW'(1));

  // One multiply or divide step computed from the current registers.
  always_comb begin
    rem_sh   = {acc, sh[W-1]};
    ge       = (rem_sh >= {1'b0, opd});
    acc_next = acc;
    sh_next  = sh;
    opd_next = opd;
    if (op_q == OP_MUL) begin
      acc_next = acc + (sh[0] ? opd : '0);
      sh_next  = sh >> 1;
      opd_next = opd << 1;
    end else begin
      // A zero divisor always compares ge, which yields all-ones quotient and remainder = dividend.
      acc_next = ge ? (rem_sh[W-1:0] - opd) : rem_sh[W-1:0];
      sh_next  = {sh[W-2:0], ge};
    end
  end

  assign result = (op_q == OP_DIVU) ? sh_next : acc_next;

  // Load operands on start, then step and count down while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      sh    <= '0;
      opd   <= '0;
      op_q  <= OP_AND;
      count <= '0;
    end else if (start) begin
      acc   <= '0;
      op_q  <= op;
      count <= CW'(DATA_WIDTH_P);
      if (op == OP_MUL) begin
        sh  <= b;
        opd <= a;
      end else begin
        sh  <= a;
        opd <= b;
      end
    end else if (busy) begin
      acc   <= acc_next;
      sh    <= sh_next;
      opd   <= opd_next;
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift/compare ops plus iterative
// MUL/DIVU/REMU, with registered result and flags behind a valid/ready handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH_P  = 32,
  parameter int CNTRL_WIDTH_P = 4
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus,
  output alu_state_e dbg_state,
  output logic       dbg_busy
);
  localparam int W   = DATA_WIDTH_P;
  localparam int SHW = $clog2(DATA_WIDTH_P);

  alu_state_e               state, state_next;
  logic                     ready, valid, accept, start, single;
  logic [CNTRL_WIDTH_P-1:0] op;
  logic [W-1:0]             a, b, sum, diff, alu_result;
  logic [SHW-1:0]           shamt;
  logic                     alu_ovf, alu_err;
  logic [W-1:0]             result_q;
  logic                     zero_q, ovf_q, err_q;
  logic                     eng_busy, eng_done;
  logic [W-1:0]             eng_result;

  assign op    = bus.i_control;
  assign a     = bus.i_a;
  assign b     = bus.i_b;
  assign shamt = b[SHW-1:0];
  assign sum   = a + b;
  assign diff  = a - b;

  assign accept = bus.i_valid && ready;
  assign start  = accept && is_iterative(op);
  assign single = accept && !is_iterative(op);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: DONE can chain straight into a new op when the result is taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = is_iterative(op) ? ITER : DONE;
      ITER: if (eng_done) state_next = DONE;
      DONE: begin
        if (bus.i_ready) begin
          if (accept) state_next = is_iterative(op) ? ITER : DONE;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs; ready in DONE passes i_ready through combinationally.
  always_comb begin
    ready = 1'b0;
    valid = 1'b0;
    case (state)
      IDLE: ready = 1'b1;
      DONE: begin
        valid = 1'b1;
        ready = bus.i_ready;
      end
      default: ;
    endcase
  end

  // Single-cycle datapath; illegal opcodes give zero result with err set.
  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    alu_err    = 1'b0;
    case (op)
      OP_AND:  alu_result = a & b;
      OP_OR:   alu_result = a | b;
      OP_XOR:  alu_result = a ^ b;
      OP_ADD: begin
        alu_result = sum;
        alu_ovf    = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        alu_result = diff;
        alu_ovf    = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_SLL:  alu_result = a << shamt;
      OP_SRL:  alu_result = a >> shamt;
      OP_SRA:  alu_result = W'($signed(a) >>> shamt);
      OP_SLT:  alu_result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_result = {{(W-1){1'b0}}, (a < b)};
      OP_MUL, OP_DIVU, OP_REMU: ;
      default: alu_err = 1'b1;
    endcase
  end

  // Output registers load only on a single-cycle accept or the engine's final step,
  // so they stay frozen while a result waits for i_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (single) begin
      result_q <= alu_result;
      zero_q   <= (alu_result == '0);
      ovf_q    <= alu_ovf;
      err_q    <= alu_err;
    end else if (eng_done) begin
      result_q <= eng_result;
      zero_q   <= (eng_result == '0);
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end
  end

  alu_muldiv #(.DATA_WIDTH_P(DATA_WIDTH_P)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (eng_busy),
    .done   (eng_done),
    .result (eng_result)
  );

  assign bus.o_ready    = ready;
  assign bus.o_valid    = valid;
  assign bus.o_result   = result_q;
  assign bus.o_zero     = zero_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_err      = err_q;
  assign dbg_state      = state;
  assign dbg_busy       = eng_busy;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios plus a randomized stream scored against
// an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W        = 32;
  localparam int MAX_LAT  = 2 * W + 10;
  localparam int MAX_CYC  = 20000;

  logic       clk = 1'b0;
  logic       rst_n;
  alu_state_e dbg_state;
  logic       dbg_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {err, overflow, zero, result} per accepted operation.
  logic [W+2:0] exp_q[$];

  alu_seq_if #(.DATA_WIDTH_P(W), .CNTRL_WIDTH_P(4)) bus ();

  alu_seq #(.DATA_WIDTH_P(W), .CNTRL_WIDTH_P(4)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_busy  (dbg_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W+2:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb, s, max_s, min_s;
    logic [63:0] p;
    logic [W-1:0] r;
    logic        ovf, err;
    int          sh;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    max_s = (longint'(1) << (W - 1)) - 1;
    min_s = -(longint'(1) << (W - 1));
    sh    = int'(b % W);
    r     = '0;
    ovf   = 1'b0;
    err   = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b0010: begin s = sa + sb; r = W'(s); ovf = (s > max_s) || (s < min_s); end
      4'b0110: begin s = sa - sb; r = W'(s); ovf = (s > max_s) || (s < min_s); end
      4'b0100: r = a << sh;
      4'b0101: r = a >> sh;
      4'b1101: r = W'(sa >>> sh);
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1111: r = (a < b) ? 32'd1 : 32'd0;
      4'b1000: begin p = {32'b0, a} * {32'b0, b}; r = p[W-1:0]; end
      4'b1010: r = (b == 0) ? '1 : a / b;
      4'b1011: r = (b == 0) ? a : a % b;
      default: err = 1'b1;
    endcase
    return {err, ovf, (r == '0), r};
  endfunction

  // ---------------- driver ----------------
  // Offer one op with i_ready=1 from idle; report result/flags and cycles from accept to o_valid.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic z, output logic ovf,
                       output logic err, output int lat);
    int waited;
    @(negedge clk);
    bus.i_valid   = 1'b1;
    bus.i_control = op;
    bus.i_a       = a;
    bus.i_b       = b;
    bus.i_ready   = 1'b1;
    #1;
    waited = 0;
    while (!bus.o_ready && waited < MAX_LAT) begin
      @(negedge clk);
      #1;
      waited++;
    end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.i_valid = 1'b0;
    end while (!bus.o_valid && lat < MAX_LAT);
    res = bus.o_result;
    z   = bus.o_zero;
    ovf = bus.o_overflow;
    err = bus.o_err;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.o_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", bus.o_valid); end
    n_checks++; if (bus.o_result !== '0)     begin n_fail++; $display("FAIL reset_result: got %h expected 0", bus.o_result); end
    n_checks++; if (bus.o_zero !== 1'b0)     begin n_fail++; $display("FAIL reset_zero: got %0b expected 0", bus.o_zero); end
    n_checks++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", bus.o_overflow); end
    n_checks++; if (bus.o_err !== 1'b0)      begin n_fail++; $display("FAIL reset_err: got %0b expected 0", bus.o_err); end
    n_checks++; if (bus.o_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", bus.o_ready); end
    n_checks++; if (dbg_state !== IDLE)      begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_overflow();
    logic [W-1:0] res; logic z, o, e; int lat;
    do_op(4'b0010, 32'h7FFF_FFFF, 32'h1, res, z, o, e, lat);
    n_checks++; if (lat !== 1)              begin n_fail++; $display("FAIL add_latency: got %0d expected 1", lat); end
    n_checks++; if (res !== 32'h8000_0000)  begin n_fail++; $display("FAIL add_result: got %h expected 80000000", res); end
    n_checks++; if (o !== 1'b1)             begin n_fail++; $display("FAIL add_ovf: got %0b expected 1", o); end
    n_checks++; if (z !== 1'b0)             begin n_fail++; $display("FAIL add_zero: got %0b expected 0", z); end
    n_checks++; if (e !== 1'b0)             begin n_fail++; $display("FAIL add_err: got %0b expected 0", e); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_ready = 1'b1;
    bus.i_control = 4'b0110; bus.i_a = 32'd5; bus.i_b = 32'd5;
    @(negedge clk);
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_result !== '0 || bus.o_zero !== 1'b1) begin
      n_fail++; $display("FAIL b2b_sub: got v=%0b r=%h z=%0b expected v=1 r=0 z=1", bus.o_valid, bus.o_result, bus.o_zero); end
    bus.i_control = 4'b0111; bus.i_a = 32'hFFFF_FFFF; bus.i_b = 32'd1;
    #1;
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %0b expected 1", bus.o_ready); end
    @(negedge clk);
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_result !== 32'd1 || bus.o_zero !== 1'b0) begin
      n_fail++; $display("FAIL b2b_slt: got v=%0b r=%h z=%0b expected v=1 r=1 z=0", bus.o_valid, bus.o_result, bus.o_zero); end
    bus.i_control = 4'b1111;
    @(negedge clk);
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_result !== '0 || bus.o_zero !== 1'b1) begin
      n_fail++; $display("FAIL b2b_sltu: got v=%0b r=%h z=%0b expected v=1 r=0 z=1", bus.o_valid, bus.o_result, bus.o_zero); end
    bus.i_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %0b expected 0", bus.o_valid); end
  endtask

  task automatic test_muldiv();
    logic [3:0]   ops[5]  = '{4'b1000, 4'b1010, 4'b1011, 4'b1010, 4'b1011};
    logic [W-1:0] as[5]   = '{32'h0001_0003, 32'd100, 32'd100, 32'd9, 32'd9};
    logic [W-1:0] bs[5]   = '{32'h0002_0005, 32'd7, 32'd7, 32'd0, 32'd0};
    logic [W-1:0] exps[5] = '{32'h000B_000F, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
    logic [W-1:0] res; logic z, o, e; int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], as[i], bs[i], res, z, o, e, lat);
      n_checks++; if (lat !== W + 1) begin n_fail++; $display("FAIL muldiv_latency[%0d]: got %0d expected %0d", i, lat, W + 1); end
      n_checks++; if (res !== exps[i] || e !== 1'b0) begin
        n_fail++; $display("FAIL muldiv_result[%0d]: got %h err=%0b expected %h err=0", i, res, e, exps[i]); end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_ready = 1'b0;
    bus.i_control = 4'b1101; bus.i_a = 32'h8000_0000; bus.i_b = 32'h24;
    @(negedge clk);
    bus.i_control = 4'b0010; bus.i_a = 32'd1; bus.i_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (bus.o_valid !== 1'b1 || bus.o_result !== 32'hF800_0000 || bus.o_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%0b r=%h rdy=%0b expected v=1 r=f8000000 rdy=0",
                           i, bus.o_valid, bus.o_result, bus.o_ready); end
      @(negedge clk);
    end
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    #1;
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b expected 1", bus.o_ready); end
    @(negedge clk);
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_handoff: got %0b expected 0", bus.o_valid); end
  endtask

  task automatic test_reset_mid_iter();
    logic [W-1:0] res; logic z, o, e; int lat; logic seen;
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_ready = 1'b1;
    bus.i_control = 4'b1010; bus.i_a = 32'd1000; bus.i_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.o_valid !== 1'b0 || bus.o_result !== '0 || bus.o_err !== 1'b0 || bus.o_zero !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got v=%0b r=%h z=%0b e=%0b expected all 0",
                         bus.o_valid, bus.o_result, bus.o_zero, bus.o_err); end
    n_checks++; if (dbg_state !== IDLE || dbg_busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state: got st=%0d busy=%0b expected st=%0d busy=0", dbg_state, dbg_busy, IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.o_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_result: got %0b expected 0", seen); end
    do_op(4'b0010, 32'd2, 32'd3, res, z, o, e, lat);
    n_checks++; if (res !== 32'd5 || lat !== 1) begin
      n_fail++; $display("FAIL midreset_add: got r=%h lat=%0d expected r=5 lat=1", res, lat); end
  endtask

  task automatic test_illegal();
    logic [3:0]   codes[4] = '{4'b1001, 4'b1100, 4'b1110, 4'b1110};
    logic [W-1:0] res; logic z, o, e; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(codes[i], $urandom(), $urandom(), res, z, o, e, lat);
      n_checks++; if (e !== 1'b1 || res !== '0 || z !== 1'b1 || o !== 1'b0 || lat !== 1) begin
        n_fail++; $display("FAIL illegal[%b]: got err=%0b r=%h z=%0b ovf=%0b lat=%0d expected err=1 r=0 z=1 ovf=0 lat=1",
                           codes[i], e, res, z, o, lat); end
    end
  endtask

  task automatic test_random(input int n_ops);
    int           issued = 0;
    int           cycles = 0;
    logic         pending = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic [W+2:0] exp, got;
    exp_q.delete();
    @(negedge clk);
    while ((issued < n_ops || pending || exp_q.size() != 0) && cycles < MAX_CYC) begin
      if (!pending && issued < n_ops && $urandom_range(0, 3) != 0) begin
        op = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
          0: a = 32'h7FFF_FFFF;
          1: a = 32'h8000_0000 | 32'($urandom_range(0, 255));
          default: a = $urandom();
        endcase
        case ($urandom_range(0, 3))
          0: b = '0;
          1: b = 32'($urandom_range(1, 40));
          default: b = $urandom();
        endcase
        pending = 1'b1;
        issued++;
      end
      bus.i_valid   = pending;
      bus.i_control = op;
      bus.i_a       = a;
      bus.i_b       = b;
      bus.i_ready   = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.o_valid && bus.i_ready) begin
        got = {bus.o_err, bus.o_overflow, bus.o_zero, bus.o_result};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL random_unexpected: got %h expected no result", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++; $display("FAIL random_result: got {err,ovf,zero,res}=%h expected %h", got, exp);
          end
        end
      end
      if (pending && bus.o_ready) begin
        exp_q.push_back(model(op, a, b));
        pending = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    bus.i_valid = 1'b0;
    n_checks++;
    if (cycles >= MAX_CYC || pending || exp_q.size() != 0) begin
      n_fail++; $display("FAIL random_drain: got cycles=%0d outstanding=%0d expected all results within %0d cycles",
                         cycles, exp_q.size(), MAX_CYC);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n         = 1'b1;
    bus.i_valid   = 1'b0;
    bus.i_ready   = 1'b0;
    bus.i_control = '0;
    bus.i_a       = '0;
    bus.i_b       = '0;
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_muldiv();
    test_backpressure();
    test_reset_mid_iter();
    test_illegal();
    test_random(80);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, parametrised successor to the single-cycle ALU for the brimstone core datapath. It accepts one operation at a time over a valid/ready handshake and keeps the existing AND/OR/ADD/SUB/SLT encodings. It adds XOR, shifts, unsigned compare, and iterative multiply/divide/remainder. Results are registered with status flags, and back-pressure is honoured.

## Interface
- DATA_WIDTH_P, 32, operand/result width; power of two, ≥ 8
- CNTRL_WIDTH_P, 4, opcode width; fixed at 4
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- i_valid  input  1  operation offered
- o_ready  output  1  block can accept operation this cycle
- i_control  input  CNTRL_WIDTH_P  opcode
- i_a  input  DATA_WIDTH_P  operand A
- i_b  input  DATA_WIDTH_P  operand B
- o_valid  output  1  result held
- i_ready  input  1  consumer takes result
- o_result  output  DATA_WIDTH_P  result
- o_zero  output  1  o_result == 0
- o_overflow  output  1  signed overflow (ADD/SUB only, else 0)
- o_err  output  1  illegal opcode

## Operation
- Opcodes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011
  - SLL 0100, SRL 0101, SUB 0110, SLT 0111 (signed)
  - MUL 1000 (low W bits of product), DIVU 1010, REMU 1011
  - SRA 1101, SLTU 1111
  - All other codes are illegal.
- Width rules:
  - Shift amount is i_b[log2(W)-1:0]; upper bits are ignored.
  - SLT/SLTU produce 0 or 1, zero-extended.
  - ADD/SUB wrap modulo 2^W. o_overflow follows the sign rule, e.g. ADD: sign(a)==sign(b) and sign(res)!=sign(a).
- Divide by zero: DIVU returns all ones; REMU returns i_a. o_err stays 0.
- Illegal opcode: o_result=0, o_zero=1, o_err=1. Completes with single-cycle latency.
- Accept is i_valid && o_ready at a rising edge. Operands and opcode are captured at that edge.
- o_ready = (state==IDLE) || (state==DONE && i_ready). This is a combinational path from i_ready, and allows back-to-back operation.
- FSM states:
  - IDLE: on accept of a single-cycle or illegal op, compute and go to DONE. On accept of MUL/DIVU/REMU, go to ITER. Otherwise stay.
  - ITER: one shift-add (MUL) or restoring-subtract (DIVU/REMU) step per cycle. A step counter starts at DATA_WIDTH_P and decrements each cycle. At counter==1 the final step completes and the state goes to DONE.
  - DONE: o_valid=1.
    - If i_ready and i_valid, accept the new op (same rules as IDLE).
    - If i_ready without i_valid, go to IDLE.
    - If !i_ready, hold.
- o_result, o_zero, o_overflow and o_err are stable while o_valid && !i_ready.
- i_valid is ignored while in ITER, and while in DONE with !i_ready.

## Timing
- Reset (asserted): state=IDLE, o_valid=0, o_result=0, o_zero=0, o_overflow=0, o_err=0, counter=0. o_ready=1 follows from IDLE.
- Single-cycle op accepted at edge N: o_valid is high in cycle N+1 (latency 1).
- Iterative op accepted at edge N: o_valid is high from cycle N+1+DATA_WIDTH_P.
- Throughput, single-cycle ops with i_ready held at 1: one result per cycle.
- Throughput, iterative ops: one result per DATA_WIDTH_P+1 cycles.
- Reset asserted mid-ITER or mid-DONE: the operation is abandoned, no result is produced, and all outputs take their reset values asynchronously.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD … OP_REMU)
  - the state encoding (IDLE, ITER, DONE)
  - a function is_iterative(op)
- Sub-module alu_muldiv holds the iterative engine: the accumulator/remainder, quotient/multiplier shift registers and the step counter.
  - Control: start/busy/done.
  - It is instantiated once; the top holds the FSM, the combinational ops and the output registers.

## Test plan
- Reset release, then ADD a=0x7FFFFFFF b=1, i_ready=1 → o_valid one cycle later, o_result=0x80000000, o_overflow=1, o_zero=0.
- Back-to-back SUB 5-5 then SLT a=0xFFFFFFFF b=1, i_ready=1 → consecutive cycles give {0, zero=1} then {1, zero=0}. The same SLT issued as SLTU → 0.
- MUL a=0x00010003 b=0x00020005 → o_valid exactly 33 cycles after accept, o_result=0x000B000F.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- Back-pressure: SRA a=0x80000000 b=0x24 (shift 4) with i_ready=0 for 5 cycles → result 0xF8000000 held stable, o_ready=0, a new i_valid is ignored; release i_ready → handoff.
- Reset at cycle 10 of a DIVU → o_valid stays 0, and the next ADD 2+3 → 5 with normal latency. Opcode 1110 → o_err=1, o_result=0.
